regfile_dump_sequencer: RTL and testbench
=========================================

Name: regfile_dump_sequencer

Overview:
- Sequences a debug dump of the pipelined CPU's architectural state for the simulation console / UART debug path.
- On a start pulse it snapshots the PC and emits a header beat. It then walks a fixed list of 18 registers: $s0-$s7 (16-23), $t0-$t7 (8-15), $t8, $t9 (24, 25).
- It borrows register-file read port 1 only in cycles the pipeline leaves it idle, and streams each value out on a valid/ready interface.

Parameters:
- DATA_W, 32, register/PC data width.
- ADDR_W, 5, register index width.
- STARVE_LIMIT, 8, consecutive denied fetch cycles before the starvation guard fires (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  dump request pulse; sampled only in IDLE.
- pc_in  in  DATA_W  current PC; captured when start is accepted.
- pipe_rd_req  in  1  pipeline is using read port 1 this cycle.
- rd_data  in  DATA_W  combinational read data of port 1.
- dbg_rd_grant  out  1  selects the debug address onto port 1.
- dbg_rd_addr  out  ADDR_W  register index driven when granted.
- pipe_stall  out  1  stalls the pipeline (optional feature only).
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_kind  out  1  1 = header (PC), 0 = register beat.
- out_idx  out  ADDR_W  register index; 0 on a header beat.
- out_data  out  DATA_W  PC snapshot or register value.
- out_tag  out  8  dump sequence number.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at dump completion.

Behaviour:
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All outputs are 0, including out_tag; the sequence pointer is 0.
  - A dump in progress is abandoned; no done pulse is generated.
- FSM states and transitions:
  - IDLE: start=1 moves to HEADER, captures pc_in and clears the pointer.
  - HEADER: out_valid=1, out_kind=1, out_data=PC snapshot, out_idx=0. Moves to FETCH on out_valid&&out_ready.
  - FETCH: while pipe_rd_req=1, dbg_rd_grant=0 and the FSM stays in FETCH. When pipe_rd_req=0, dbg_rd_grant=1 and dbg_rd_addr=seq[ptr]; rd_data is latched at the edge and the FSM moves to EMIT.
  - EMIT: out_valid=1, out_kind=0, out_idx=seq[ptr], out_data=latched value. On handshake, if ptr==17 go to DONE, else ptr++ and return to FETCH.
  - DONE: done=1 for exactly one cycle, out_tag increments, then IDLE.
- Port rules:
  - dbg_rd_grant is combinational and only ever high in FETCH with pipe_rd_req=0.
  - The pipeline always wins the port (unless the optional feature fires).
- Output stream rules:
  - out_valid is held with out_idx, out_data, out_kind and out_tag stable until accepted.
  - out_valid is never dropped without a handshake.
  - out_ready is ignored when out_valid=0.
- Latency with no port contention and out_ready held high:
  - Start accepted at edge E0; header valid after E0.
  - Each register takes 2 cycles (FETCH + EMIT).
  - DONE occupies the cycle after E37; IDLE after E38.
- Boundary cases:
  - start while busy: ignored, not queued.
  - start during DONE: ignored.
  - out_tag wraps 255 to 0.
  - The latched value is the value read at grant time; later register writes do not alter a pending beat.

Optional Feature:
- Macro: DUMP_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive FETCH cycles with pipe_rd_req=1.
  - When the count reaches STARVE_LIMIT, the next cycle asserts pipe_stall=1 and dbg_rd_grant=1 regardless of pipe_rd_req, and latches rd_data.
  - The counter clears on any grant and on leaving FETCH.
  - pipe_stall is high for exactly that one cycle.
- Not defined:
  - pipe_stall is tied to 0, the counter is absent, and the debug path may wait indefinitely.

Test Plan:
- Reset mid-dump: assert reset_n=0 during EMIT of register 19 -> all outputs 0 immediately, no done pulse; a new start then yields header beat with out_tag=0.
- Clean dump: regs preloaded with 32'h1000_00NN (NN = index), PC=32'h0040_0020, out_ready=1, no contention.
  - Beats arrive in order: header 00400020, then idx 16..23, 8..15, 24, 25 with matching data.
  - done at cycle 38 after start; out_tag becomes 1.
- Backpressure: out_ready=0 for 5 cycles on idx 20 -> beat held stable, no FETCH advance; resumes with idx 21 after acceptance.
- Contention: pipe_rd_req=1 for 3 cycles at each FETCH -> dbg_rd_grant never overlaps pipe_rd_req; all 18 values still correct.
- Ignored start: start pulsed during FETCH and during DONE -> no restart; exactly 19 beats and one done pulse; 256 back-to-back dumps -> out_tag wraps to 0.
- With DUMP_STARVE_GUARD_EN, pipe_rd_req held at 1 -> after 8 denied cycles pipe_stall=1 for one cycle with grant high, and the correct value is emitted; without the macro, the dump stalls in FETCH and pipe_stall stays 0.

Source files
------------

// File: rtl/regfile_dump_sequencer.sv
// regfile_dump_sequencer
//
// Sequences a debug dump of the CPU architectural state. A start pulse
// snapshots the PC and emits a header beat. The block then walks 18 registers
// in the order $s0-$s7 (16-23), $t0-$t7 (8-15), $t8, $t9 (24, 25). It borrows
// register-file read port 1 only in cycles the pipeline leaves it idle, and
// streams each value on a valid/ready interface.
//
// Optional feature: define DUMP_STARVE_GUARD_EN to enable the starvation
// guard. After STARVE_LIMIT consecutive denied fetch cycles, the block stalls
// the pipeline for one cycle and takes the read port.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   start            dump request, sampled only while idle
//   pc_in            PC captured when start is accepted
//   pipe_rd_req      pipeline is using read port 1 this cycle
//   rd_data          combinational read data of port 1
//   dbg_rd_grant     selects dbg_rd_addr onto port 1
//   dbg_rd_addr      register index driven while granted
//   pipe_stall       one-cycle pipeline stall from the starvation guard
//   out_valid/ready  output beat handshake
//   out_kind         1 = header (PC) beat, 0 = register beat
//   out_idx          register index, 0 on the header beat
//   out_data         PC snapshot or register value
//   out_tag          dump sequence number, increments at each completion
//   busy             dump in progress
//   done             one-cycle pulse at dump completion
module regfile_dump_sequencer #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              pipe_rd_req,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dbg_rd_grant,
    output logic [ADDR_W-1:0] dbg_rd_addr,
    output logic              pipe_stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_kind,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_tag,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] LastPtr = 5'd17;

    typedef enum logic [2:0] {StIdle, StHeader, StFetch, StEmit, StDone} state_e;

    state_e            state_q, state_d;
    logic [4:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        tag_q, tag_d;
    logic [4:0]        seq_idx;
    logic              force_grant;

    // Pointer to register index: 0-7 -> 16-23, 8-15 -> 8-15, 16-17 -> 24-25.
    always_comb begin
        seq_idx = ptr_q;
        if (ptr_q < 5'd8) begin
            seq_idx = ptr_q + 5'd16;
        end else if (ptr_q >= 5'd16) begin
            seq_idx = ptr_q + 5'd8;
        end
    end

`ifdef DUMP_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    assign force_grant = (state_q == StFetch) && (starve_cnt_q == CntW'(STARVE_LIMIT));

    // Count consecutive denied fetch cycles; any grant or leaving fetch clears.
    always_comb begin
        starve_cnt_d = '0;
        if (state_q == StFetch && !dbg_rd_grant) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_grant = 1'b0;
`endif

    assign busy    = (state_q != StIdle);
    assign out_tag = tag_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        pc_d         = pc_q;
        data_d       = data_q;
        tag_d        = tag_q;
        dbg_rd_grant = 1'b0;
        dbg_rd_addr  = '0;
        pipe_stall   = 1'b0;
        out_valid    = 1'b0;
        out_kind     = 1'b0;
        out_idx      = '0;
        out_data     = '0;
        done         = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHeader;
                    pc_d    = pc_in;
                    ptr_d   = '0;
                end
            end
            StHeader: begin
                out_valid = 1'b1;
                out_kind  = 1'b1;
                out_data  = pc_q;
                if (out_ready) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                pipe_stall = force_grant;
                // The pipeline owns the port unless the starvation guard fires.
                if (!pipe_rd_req || force_grant) begin
                    dbg_rd_grant = 1'b1;
                    dbg_rd_addr  = ADDR_W'(seq_idx);
                    data_d       = rd_data;
                    state_d      = StEmit;
                end
            end
            StEmit: begin
                out_valid = 1'b1;
                out_idx   = ADDR_W'(seq_idx);
                out_data  = data_q;
                if (out_ready) begin
                    if (ptr_q == LastPtr) begin
                        state_d = StDone;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                tag_d   = tag_q + 8'd1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            pc_q    <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Testbench for regfile_dump_sequencer: randomized stimulus checked every cycle
// against a beat-level model of the dump, plus literal expectations.
module tb_regfile_dump_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pipe_rd_req = 1'b0;
    logic [31:0] rd_data;
    logic        dbg_rd_grant;
    logic [4:0]  dbg_rd_addr;
    logic        pipe_stall;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_kind;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic [7:0]  out_tag;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [31:0] pipe_junk = '0;

    // Port 1 returns the debug register when granted, else pipeline traffic.
    assign rd_data = dbg_rd_grant ? regs[dbg_rd_addr] : pipe_junk;

    regfile_dump_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .pc_in        (pc_in),
        .pipe_rd_req  (pipe_rd_req),
        .rd_data      (rd_data),
        .dbg_rd_grant (dbg_rd_grant),
        .dbg_rd_addr  (dbg_rd_addr),
        .pipe_stall   (pipe_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_idx      (out_idx),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus driver ----------------
    int rdy_mode  = 0;  // 0 always ready, 1 random, 2 hold 5 cycles on idx 20
    int pipe_mode = 0;  // 0 idle, 1 random, 2 held, 3 bursts of 3
    bit mutate    = 1'b0;
    int bp_left   = 0;
    bit bp_used   = 1'b0;
    int pipe_left = 0;

    always @(posedge clock) begin
        #1;
        pipe_junk = $urandom;
        if (rdy_mode == 2 && !bp_used && out_valid && !out_kind && out_idx == 5'd20) begin
            bp_left = 5;
            bp_used = 1'b1;
        end
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (bp_left > 0) begin
                    out_ready = 1'b0;
                    bp_left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
        case (pipe_mode)
            0: pipe_rd_req = 1'b0;
            1: pipe_rd_req = ($urandom_range(0, 1) == 1);
            2: pipe_rd_req = 1'b1;
            default: begin
                if (pipe_left > 0) begin
                    pipe_rd_req = 1'b1;
                    pipe_left--;
                end else begin
                    pipe_rd_req = 1'b0;
                    if ($urandom_range(0, 1) == 1) pipe_left = 3;
                end
            end
        endcase
        // Pipeline writeback: may hit a register whose beat is pending.
        if (mutate) regs[$urandom_range(0, 31)] = $urandom;
    end

    // ---------------- behavioural model + compare ----------------
    typedef struct {
        logic        kind;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [7:0]  tag;
    } beat_t;

    int          seq_tab [18] = '{16, 17, 18, 19, 20, 21, 22, 23,
                                  8, 9, 10, 11, 12, 13, 14, 15, 24, 25};
    int          m_phase = 0;   // 0 idle, 1 dumping, 2 completion cycle
    int          m_beat = 0;    // 0 = header, k = register k-1
    bit          m_fetched = 1'b0;
    int          m_deny = 0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_val = '0;
    logic [7:0]  m_tag = '0;
    int          m_start_edge = 0;
    int          done_delta = -1;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    beat_t       log_q [$];

    always @(negedge clock) begin
        bit fetching;
        bit e_stall;
        bit e_grant;
        bit e_valid;
        if (!reset_n) begin
            chk("reset_outputs",
                {out_valid, out_kind, out_idx, out_data, out_tag, busy, done,
                 dbg_rd_grant, dbg_rd_addr, pipe_stall}, 64'd0);
            m_phase   = 0;
            m_tag     = '0;
            m_deny    = 0;
            m_fetched = 1'b0;
        end else begin
            fetching = (m_phase == 1) && (m_beat >= 1) && !m_fetched;
`ifdef DUMP_STARVE_GUARD_EN
            e_stall = fetching && (m_deny == 8);
`else
            e_stall = 1'b0;
`endif
            e_grant = fetching && (!pipe_rd_req || e_stall);
            e_valid = (m_phase == 1) && (m_beat == 0 || m_fetched);

            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == 2);
            chk("pipe_stall", pipe_stall, e_stall);
            chk("dbg_rd_grant", dbg_rd_grant, e_grant);
            chk("grant_overlap", dbg_rd_grant & pipe_rd_req & ~pipe_stall, 1'b0);
            chk("out_valid", out_valid, e_valid);
            chk("out_tag", out_tag, m_tag);
            if (e_grant) chk("dbg_rd_addr", dbg_rd_addr, seq_tab[m_beat-1]);
            if (e_valid) begin
                chk("out_kind", out_kind, m_beat == 0);
                chk("out_idx", out_idx, (m_beat == 0) ? 0 : seq_tab[m_beat-1]);
                chk("out_data", out_data, (m_beat == 0) ? m_pc : m_val);
            end
            if (pipe_stall) stall_cnt++;
            if (done) begin
                done_cnt++;
                done_delta = cyc - m_start_edge;
            end

            // Advance the model to the state after the coming edge.
            if (fetching) m_deny = e_grant ? 0 : m_deny + 1;
            else m_deny = 0;
            if (e_grant) begin
                m_val     = regs[seq_tab[m_beat-1]];
                m_fetched = 1'b1;
            end
            case (m_phase)
                0: if (start) begin
                    m_phase      = 1;
                    m_beat       = 0;
                    m_fetched    = 1'b0;
                    m_pc         = pc_in;
                    m_start_edge = cyc + 1;
                end
                1: if (e_valid && out_ready) begin
                    log_q.push_back('{out_kind, out_idx, out_data, out_tag});
                    if (m_beat == 18) begin
                        m_phase = 2;
                    end else begin
                        m_beat++;
                        m_fetched = 1'b0;
                    end
                end
                default: begin
                    m_phase = 0;
                    m_tag   = m_tag + 8'd1;
                end
            endcase
        end
    end

    // ---------------- sequencing ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] pc);
        start = 1'b1;
        pc_in = pc;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int target = done_cnt + 1;
        for (int k = 0; k < budget && done_cnt < target; k++) @(posedge clock);
        #1;
        chk("done_timeout", done_cnt, target);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 | i;

        // Reset state.
        reset_n = 1'b0;
        tick(3);
        chk("reset_busy_tag_valid", {busy, out_tag, out_valid, done}, 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Clean dump.
        log_q.delete();
        pulse_start(32'h0040_0020);
        wait_done(200);
        chk("clean_beats", log_q.size(), 19);
        if (log_q.size() == 19) begin
            chk("hdr_kind", log_q[0].kind, 1'b1);
            chk("hdr_data", log_q[0].data, 32'h0040_0020);
            chk("hdr_idx", log_q[0].idx, 5'd0);
            chk("beat1", {log_q[1].idx, log_q[1].data}, {5'd16, 32'h1000_0010});
            chk("beat8", {log_q[8].idx, log_q[8].data}, {5'd23, 32'h1000_0017});
            chk("beat9", {log_q[9].idx, log_q[9].data}, {5'd8, 32'h1000_0008});
            chk("beat18", {log_q[18].idx, log_q[18].data}, {5'd25, 32'h1000_0019});
        end
        // done sits in the cycle after edge E37 counted from the accepting edge E0.
        chk("clean_done_latency", done_delta, 37);
        chk("clean_tag", out_tag, 8'd1);

        // Backpressure on idx 20.
        rdy_mode = 2;
        bp_used  = 1'b0;
        log_q.delete();
        pulse_start($urandom);
        wait_done(200);
        chk("bp_applied", bp_used, 1'b1);
        chk("bp_order", {log_q[5].idx, log_q[6].idx}, {5'd20, 5'd21});
        chk("bp_latency", done_delta, 42);

        // Contention, random backpressure and register writes.
        rdy_mode  = 1;
        pipe_mode = 3;
        mutate    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse_start($urandom);
            wait_done(600);
        end
        pipe_mode = 1;
        for (int i = 0; i < 3; i++) begin
            pulse_start($urandom);
            wait_done(600);
        end

        // Start pulses during fetch and during completion are ignored.
        rdy_mode  = 0;
        pipe_mode = 0;
        mutate    = 1'b0;
        log_q.delete();
        d0 = done_cnt;
        pulse_start(32'hCAFE_0000);
        tick(7);
        pulse_start(32'hDEAD_BEEF);
        for (int k = 0; k < 100 && !done; k++) @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        tick(4);
        chk("ignored_beats", log_q.size(), 19);
        chk("ignored_done_cnt", done_cnt - d0, 1);
        chk("ignored_idle", busy, 1'b0);

        // Reset while register 19 is being emitted.
        rdy_mode = 1;
        pulse_start(32'h1234_5678);
        for (int k = 0; k < 200 && !(out_valid && !out_kind && out_idx == 5'd19); k++)
            @(negedge clock);
        chk("reached_idx19", {out_valid, out_kind, out_idx}, {1'b1, 1'b0, 5'd19});
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {out_valid, out_tag, busy, done, out_data}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        tick(3);
        chk("reset_no_done", done_cnt, d0);
        log_q.delete();
        rdy_mode = 0;
        pulse_start(32'h0000_0100);
        wait_done(200);
        chk("post_reset_hdr", {log_q[0].kind, log_q[0].tag}, {1'b1, 8'd0});
        chk("post_reset_tag", out_tag, 8'd1);

        // Pipeline holds the read port.
        pipe_mode = 2;
        log_q.delete();
        stall_cnt = 0;
        pulse_start(32'h0BAD_F00D);
`ifdef DUMP_STARVE_GUARD_EN
        wait_done(600);
        chk("starve_stalls", stall_cnt, 18);
        chk("starve_beats", log_q.size(), 19);
`else
        tick(40);
        chk("starve_busy", busy, 1'b1);
        chk("starve_only_header", log_q.size(), 1);
        chk("starve_no_stall", stall_cnt, 0);
        pipe_mode = 0;
        wait_done(200);
`endif
        chk("starve_tag", out_tag, 8'd2);

        // Back-to-back dumps until the tag wraps.
        pipe_mode = 1;
        for (int i = 0; i < 254; i++) begin
            pulse_start($urandom);
            wait_done(400);
        end
        chk("tag_wrap", out_tag, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
